// File: rtl/pwrmgr_pkg.sv
// ---------------------------------------------------------------------------
// pwrmgr_pkg
//
// Shared types for the power manager.
//   pwrup_cause_e    : reason for the most recent power-up, published by the
//                      slow-domain sequencer to the fast domain.
//   slow_seq_state_e : state encoding of the slow-domain power sequencer,
//                      exported on its state_o debug port.
// ---------------------------------------------------------------------------
package pwrmgr_pkg;

    typedef enum logic [1:0] {
        Por   = 2'd0,
        Wake  = 2'd1,
        Reset = 2'd2
    } pwrup_cause_e;

    typedef enum logic [3:0] {
        StReset         = 4'd0,
        StMainPowerUp   = 4'd1,
        StClocksOn      = 4'd2,
        StClampOff      = 4'd3,
        StReqPwrUp      = 4'd4,
        StIdle          = 4'd5,
        StAckPwrDn      = 4'd6,
        StClampOn       = 4'd7,
        StClocksOff     = 4'd8,
        StMainPowerDown = 4'd9,
        StLowPower      = 4'd10
    } slow_seq_state_e;

    // The clamp dwell counter covers the full 1..255 range of ClampDelay.
    localparam int unsigned ClampCntWidth = $clog2(256);

endpackage

// File: rtl/pwrmgr_slow_seq.sv
// ---------------------------------------------------------------------------
// pwrmgr_slow_seq
//
// Slow-domain power sequencer. Responds to the fast-domain power FSM:
// acknowledges power-down requests, drives the AST main-power / clamp /
// clock-enable controls step by step while waiting on AST status, and
// requests power-up once power and clocks are back. The power-up cause is
// published as a value plus a toggle that the fast side edge-detects.
//
// Ports
//   clk_i                 slow always-on clock
//   rst_i                 synchronous active-high reset
//   req_pwrdn_i           fast-domain power-down request (synchronized)
//   ack_pwrup_i           fast-domain power-up acknowledge (synchronized)
//   wakeup_i              OR of masked wakeup requests
//   reset_req_i           OR of masked reset requests
//   main_pd_ni            config: 0 powers main down during low power
//   io_clk_en_i           config: keep io clock on during low power
//   core_clk_en_i         config: keep core clock on during low power
//   main_pok_i            AST main power good
//   io_clk_val_i          AST io clock valid
//   core_clk_val_i        AST core clock valid
//   req_pwrup_o           power-up request to fast side
//   ack_pwrdn_o           power-down acknowledge to fast side
//   pwrup_cause_toggle_o  flips once per power-up
//   pwrup_cause_o         cause of the latest power-up
//   main_pd_no            AST main power control (0 = power down)
//   pwr_clamp_o           AST isolation clamp
//   io_clk_en_o           AST io clock enable
//   core_clk_en_o         AST core clock enable
//   state_o               current state for debug
// ---------------------------------------------------------------------------
module pwrmgr_slow_seq
    import pwrmgr_pkg::*;
#(
    parameter int unsigned ClampDelay = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_pwrdn_i,
    input  logic         ack_pwrup_i,
    input  logic         wakeup_i,
    input  logic         reset_req_i,
    input  logic         main_pd_ni,
    input  logic         io_clk_en_i,
    input  logic         core_clk_en_i,
    input  logic         main_pok_i,
    input  logic         io_clk_val_i,
    input  logic         core_clk_val_i,
    output logic         req_pwrup_o,
    output logic         ack_pwrdn_o,
    output logic         pwrup_cause_toggle_o,
    output pwrup_cause_e pwrup_cause_o,
    output logic         main_pd_no,
    output logic         pwr_clamp_o,
    output logic         io_clk_en_o,
    output logic         core_clk_en_o,
    output logic [3:0]   state_o
);

    localparam logic [ClampCntWidth-1:0] ClampLoad = ClampCntWidth'(ClampDelay);

    slow_seq_state_e           state, state_next;
    logic [ClampCntWidth-1:0]  clamp_cnt, clamp_cnt_next;
    logic                      req_pwrup, req_pwrup_next;
    logic                      ack_pwrdn, ack_pwrdn_next;
    logic                      cause_toggle, cause_toggle_next;
    pwrup_cause_e              pwrup_cause, pwrup_cause_next;
    logic                      main_pd, main_pd_next;
    logic                      pwr_clamp, pwr_clamp_next;
    logic                      io_clk_en, io_clk_en_next;
    logic                      core_clk_en, core_clk_en_next;

    // State and every output are registered together, so an output changes
    // on exactly the edge that enters the state that owns it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= StReset;
            clamp_cnt    <= '0;
            req_pwrup    <= 1'b0;
            ack_pwrdn    <= 1'b0;
            cause_toggle <= 1'b0;
            pwrup_cause  <= Por;
            main_pd      <= 1'b1;
            pwr_clamp    <= 1'b1;
            io_clk_en    <= 1'b0;
            core_clk_en  <= 1'b0;
        end else begin
            state        <= state_next;
            clamp_cnt    <= clamp_cnt_next;
            req_pwrup    <= req_pwrup_next;
            ack_pwrdn    <= ack_pwrdn_next;
            cause_toggle <= cause_toggle_next;
            pwrup_cause  <= pwrup_cause_next;
            main_pd      <= main_pd_next;
            pwr_clamp    <= pwr_clamp_next;
            io_clk_en    <= io_clk_en_next;
            core_clk_en  <= core_clk_en_next;
        end
    end

    // Next-state and next-output logic. Outputs hold their value unless the
    // transition being taken changes them; config inputs are only looked at
    // on the transition into the state that applies them.
    always_comb begin
        state_next        = state;
        clamp_cnt_next    = clamp_cnt;
        req_pwrup_next    = req_pwrup;
        ack_pwrdn_next    = ack_pwrdn;
        cause_toggle_next = cause_toggle;
        pwrup_cause_next  = pwrup_cause;
        main_pd_next      = main_pd;
        pwr_clamp_next    = pwr_clamp;
        io_clk_en_next    = io_clk_en;
        core_clk_en_next  = core_clk_en;

        case (state)
            StReset: begin
                state_next   = StMainPowerUp;
                main_pd_next = 1'b1;
            end

            StMainPowerUp: begin
                if (main_pok_i) begin
                    state_next       = StClocksOn;
                    io_clk_en_next   = 1'b1;
                    core_clk_en_next = 1'b1;
                end
            end

            StClocksOn: begin
                if (io_clk_val_i && core_clk_val_i) begin
                    state_next     = StClampOff;
                    pwr_clamp_next = 1'b0;
                end
            end

            StClampOff: begin
                state_next        = StReqPwrUp;
                req_pwrup_next    = 1'b1;
                cause_toggle_next = ~cause_toggle;
            end

            StReqPwrUp: begin
                if (ack_pwrup_i) begin
                    state_next     = StIdle;
                    req_pwrup_next = 1'b0;
                end
            end

            // A power-down request is only honoured once the fast side has
            // dropped its power-up acknowledge.
            StIdle: begin
                if (!ack_pwrup_i && req_pwrdn_i) begin
                    state_next     = StAckPwrDn;
                    ack_pwrdn_next = 1'b1;
                end
            end

            StAckPwrDn: begin
                if (!req_pwrdn_i) begin
                    state_next     = StClampOn;
                    ack_pwrdn_next = 1'b0;
                    pwr_clamp_next = 1'b1;
                    clamp_cnt_next = ClampLoad;
                end
            end

            // Counter holds ClampDelay on the first cycle here; leaving when
            // it steps from 1 to 0 gives a dwell of exactly ClampDelay cycles.
            StClampOn: begin
                if (clamp_cnt != '0) begin
                    clamp_cnt_next = clamp_cnt - 1'b1;
                end
                if (clamp_cnt <= ClampCntWidth'(1)) begin
                    state_next       = StClocksOff;
                    io_clk_en_next   = io_clk_en_i;
                    core_clk_en_next = core_clk_en_i;
                end
            end

            StClocksOff: begin
                if ((io_clk_val_i == io_clk_en) && (core_clk_val_i == core_clk_en)) begin
                    state_next   = StMainPowerDown;
                    main_pd_next = main_pd_ni;
                end
            end

            StMainPowerDown: begin
                if (main_pok_i == main_pd) begin
                    state_next = StLowPower;
                end
            end

            // Reset requests take priority over wakeups when both arrive.
            StLowPower: begin
                if (reset_req_i || wakeup_i) begin
                    state_next       = StMainPowerUp;
                    pwrup_cause_next = reset_req_i ? Reset : Wake;
                    main_pd_next     = 1'b1;
                end
            end

            default: begin
                state_next = StReset;
            end
        endcase
    end

    assign req_pwrup_o          = req_pwrup;
    assign ack_pwrdn_o          = ack_pwrdn;
    assign pwrup_cause_toggle_o = cause_toggle;
    assign pwrup_cause_o        = pwrup_cause;
    assign main_pd_no           = main_pd;
    assign pwr_clamp_o          = pwr_clamp;
    assign io_clk_en_o          = io_clk_en;
    assign core_clk_en_o        = core_clk_en;
    assign state_o              = state;

endmodule

// File: tb/tb_pwrmgr_slow_seq.sv
// ---------------------------------------------------------------------------
// tb_pwrmgr_slow_seq
//
// Self-checking bench for pwrmgr_slow_seq: a table of directed vectors for
// the cold boot / power-down / wake round trip, hand-written sequences for
// deep sleep, stalled power-good and reset during a handshake, then random
// stimulus. A behavioural model of the power-sequencing rules shadows the
// DUT on every clock.
// ---------------------------------------------------------------------------
module tb_pwrmgr_slow_seq;
    import pwrmgr_pkg::*;

    localparam int unsigned ClampDelay = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_pwrdn_i, ack_pwrup_i, wakeup_i, reset_req_i;
    logic         main_pd_ni, io_clk_en_i, core_clk_en_i;
    logic         main_pok_i, io_clk_val_i, core_clk_val_i;
    logic         req_pwrup_o, ack_pwrdn_o, pwrup_cause_toggle_o;
    pwrup_cause_e pwrup_cause_o;
    logic         main_pd_no, pwr_clamp_o, io_clk_en_o, core_clk_en_o;
    logic [3:0]   state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle_no = 0;

    // Behavioural model state.
    slow_seq_state_e m_state;
    pwrup_cause_e    m_cause;
    logic            m_req, m_ack, m_tog, m_pdn, m_clamp, m_io, m_core;
    int              m_clamp_start;

    // Directed vector: inputs packed as
    // {rst, pok, io_val, core_val, ack_pwrup, req_pwrdn, wakeup, reset_req,
    //  main_pd_n cfg, io_clk_en cfg, core_clk_en cfg}
    // outputs packed as {req, ack, toggle, main_pd_n, clamp, io_en, core_en}.
    typedef struct {
        logic [10:0]     in_bits;
        slow_seq_state_e st;
        pwrup_cause_e    cause;
        logic [6:0]      outs;
    } vec_t;

    vec_t tbl [25];

    pwrmgr_slow_seq #(.ClampDelay(ClampDelay)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .req_pwrdn_i         (req_pwrdn_i),
        .ack_pwrup_i         (ack_pwrup_i),
        .wakeup_i            (wakeup_i),
        .reset_req_i         (reset_req_i),
        .main_pd_ni          (main_pd_ni),
        .io_clk_en_i         (io_clk_en_i),
        .core_clk_en_i       (core_clk_en_i),
        .main_pok_i          (main_pok_i),
        .io_clk_val_i        (io_clk_val_i),
        .core_clk_val_i      (core_clk_val_i),
        .req_pwrup_o         (req_pwrup_o),
        .ack_pwrdn_o         (ack_pwrdn_o),
        .pwrup_cause_toggle_o(pwrup_cause_toggle_o),
        .pwrup_cause_o       (pwrup_cause_o),
        .main_pd_no          (main_pd_no),
        .pwr_clamp_o         (pwr_clamp_o),
        .io_clk_en_o         (io_clk_en_o),
        .core_clk_en_o       (core_clk_en_o),
        .state_o             (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Hard stop in case something stalls the flow unexpectedly.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] in_bits);
        {rst_i, main_pok_i, io_clk_val_i, core_clk_val_i, ack_pwrup_i, req_pwrdn_i,
         wakeup_i, reset_req_i, main_pd_ni, io_clk_en_i, core_clk_en_i} = in_bits;
    endtask

    function automatic logic [12:0] dut_vec();
        return {state_o, pwrup_cause_o, req_pwrup_o, ack_pwrdn_o, pwrup_cause_toggle_o,
                main_pd_no, pwr_clamp_o, io_clk_en_o, core_clk_en_o};
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_state, m_cause, m_req, m_ack, m_tog, m_pdn, m_clamp, m_io, m_core};
    endfunction

    // Power-sequencing rules applied once per clock edge to the inputs seen
    // at that edge. Clamp dwell is measured as elapsed cycles since entry.
    task automatic model_step();
        cycle_no++;
        if (rst_i) begin
            m_state = StReset; m_cause = Por;
            m_req = 0; m_ack = 0; m_tog = 0; m_pdn = 1; m_clamp = 1; m_io = 0; m_core = 0;
            return;
        end
        case (m_state)
            StReset:       begin m_state = StMainPowerUp; m_pdn = 1; end
            StMainPowerUp: if (main_pok_i) begin m_state = StClocksOn; m_io = 1; m_core = 1; end
            StClocksOn:    if (io_clk_val_i & core_clk_val_i) begin m_state = StClampOff; m_clamp = 0; end
            StClampOff:    begin m_state = StReqPwrUp; m_req = 1; m_tog = ~m_tog; end
            StReqPwrUp:    if (ack_pwrup_i) begin m_state = StIdle; m_req = 0; end
            StIdle:        if (!ack_pwrup_i && req_pwrdn_i) begin m_state = StAckPwrDn; m_ack = 1; end
            StAckPwrDn:    if (!req_pwrdn_i) begin
                               m_state = StClampOn; m_ack = 0; m_clamp = 1; m_clamp_start = cycle_no;
                           end
            StClampOn:     if (cycle_no - m_clamp_start == int'(ClampDelay)) begin
                               m_state = StClocksOff; m_io = io_clk_en_i; m_core = core_clk_en_i;
                           end
            StClocksOff:   if (io_clk_val_i == m_io && core_clk_val_i == m_core) begin
                               m_state = StMainPowerDown; m_pdn = main_pd_ni;
                           end
            StMainPowerDown: if (main_pok_i == m_pdn) m_state = StLowPower;
            StLowPower:    if (reset_req_i || wakeup_i) begin
                               m_state = StMainPowerUp; m_pdn = 1;
                               m_cause = reset_req_i ? Reset : Wake;
                           end
            default:       m_state = StReset;
        endcase
    endtask

    task automatic step_cycle();
        @(posedge clk_i);
        model_step();
        #1;
        checkOutput("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic wait_state(input slow_seq_state_e target, input int max_cycles);
        for (int i = 0; i < max_cycles && state_o != target; i++) step_cycle();
        checkOutput($sformatf("reach_%s", target.name()), 32'(state_o), 32'(target));
    endtask

    initial begin
        tbl[0]  = '{11'b1111_0000_000, StReset,         Por,   7'b0001100};
        tbl[1]  = '{11'b0111_0000_000, StMainPowerUp,   Por,   7'b0001100};
        tbl[2]  = '{11'b0111_0000_000, StClocksOn,      Por,   7'b0001111};
        tbl[3]  = '{11'b0111_0000_000, StClampOff,      Por,   7'b0001011};
        tbl[4]  = '{11'b0111_0000_000, StReqPwrUp,      Por,   7'b1011011};
        tbl[5]  = '{11'b0111_1000_000, StIdle,          Por,   7'b0011011};
        tbl[6]  = '{11'b0111_1100_000, StIdle,          Por,   7'b0011011};
        tbl[7]  = '{11'b0111_0100_000, StAckPwrDn,      Por,   7'b0111011};
        tbl[8]  = '{11'b0111_0100_000, StAckPwrDn,      Por,   7'b0111011};
        tbl[9]  = '{11'b0111_0000_000, StClampOn,       Por,   7'b0011111};
        tbl[10] = '{11'b0111_0000_000, StClampOn,       Por,   7'b0011111};
        tbl[11] = '{11'b0111_0000_000, StClampOn,       Por,   7'b0011111};
        tbl[12] = '{11'b0111_0000_000, StClampOn,       Por,   7'b0011111};
        tbl[13] = '{11'b0111_0000_000, StClocksOff,     Por,   7'b0011100};
        tbl[14] = '{11'b0111_0000_000, StClocksOff,     Por,   7'b0011100};
        tbl[15] = '{11'b0100_0000_000, StMainPowerDown, Por,   7'b0010100};
        tbl[16] = '{11'b0100_0000_000, StMainPowerDown, Por,   7'b0010100};
        tbl[17] = '{11'b0000_0000_000, StLowPower,      Por,   7'b0010100};
        tbl[18] = '{11'b0000_0000_000, StLowPower,      Por,   7'b0010100};
        tbl[19] = '{11'b0000_0011_000, StMainPowerUp,   Reset, 7'b0011100};
        tbl[20] = '{11'b0000_0000_000, StMainPowerUp,   Reset, 7'b0011100};
        tbl[21] = '{11'b0100_0000_000, StClocksOn,      Reset, 7'b0011111};
        tbl[22] = '{11'b0111_0000_000, StClampOff,      Reset, 7'b0011011};
        tbl[23] = '{11'b0111_0000_000, StReqPwrUp,      Reset, 7'b1001011};
        tbl[24] = '{11'b0111_1000_000, StIdle,          Reset, 7'b0001011};

        applyStimulus(11'b1111_0000_000);

        // Cold boot, full power-down, simultaneous wake+reset, power-up.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(tbl[i].in_bits);
            step_cycle();
            checkOutput($sformatf("vec%0d", i), 32'(dut_vec()),
                        32'({tbl[i].st, tbl[i].cause, tbl[i].outs}));
        end

        // Deep sleep: io clock kept on, main power kept up, core clock off.
        applyStimulus(11'b0111_0100_110);
        step_cycle();
        checkOutput("deep_ack", 32'(ack_pwrdn_o), 32'd1);
        applyStimulus(11'b0111_0000_110);
        wait_state(StClocksOff, 10);
        applyStimulus(11'b0110_0000_110);
        wait_state(StLowPower, 10);
        repeat (3) step_cycle();
        checkOutput("deep_io_en", 32'(io_clk_en_o), 32'd1);
        checkOutput("deep_core_en", 32'(core_clk_en_o), 32'd0);
        checkOutput("deep_main_pd_n", 32'(main_pd_no), 32'd1);
        applyStimulus(11'b0110_0010_110);
        step_cycle();
        checkOutput("deep_cause", 32'(pwrup_cause_o), 32'(Wake));
        applyStimulus(11'b0111_0000_110);
        wait_state(StReqPwrUp, 10);
        checkOutput("deep_toggle", 32'(pwrup_cause_toggle_o), 32'd1);
        applyStimulus(11'b0111_1000_000);
        step_cycle();

        // Reset while acknowledging a power-down abandons the handshake.
        applyStimulus(11'b0111_0100_000);
        wait_state(StAckPwrDn, 5);
        applyStimulus(11'b1111_0100_000);
        step_cycle();
        checkOutput("rst_ack", 32'(ack_pwrdn_o), 32'd0);
        checkOutput("rst_clamp", 32'(pwr_clamp_o), 32'd1);
        checkOutput("rst_cause", 32'(pwrup_cause_o), 32'(Por));
        checkOutput("rst_state", 32'(state_o), 32'(StReset));

        // Main power never becomes good: sequencer must stall.
        applyStimulus(11'b0011_0000_000);
        step_cycle();
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            checkOutput("stall_state", 32'(state_o), 32'(StMainPowerUp));
            checkOutput("stall_req", 32'(req_pwrup_o), 32'd0);
        end
        applyStimulus(11'b0111_0000_000);
        wait_state(StReqPwrUp, 10);

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_i          = ($urandom_range(0, 255) == 0);
            main_pok_i     = 1'($urandom_range(0, 1));
            io_clk_val_i   = 1'($urandom_range(0, 1));
            core_clk_val_i = 1'($urandom_range(0, 1));
            ack_pwrup_i    = 1'($urandom_range(0, 1));
            req_pwrdn_i    = 1'($urandom_range(0, 1));
            wakeup_i       = ($urandom_range(0, 7) == 0);
            reset_req_i    = ($urandom_range(0, 7) == 0);
            main_pd_ni     = 1'($urandom_range(0, 1));
            io_clk_en_i    = 1'($urandom_range(0, 1));
            core_clk_en_i  = 1'($urandom_range(0, 1));
            step_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
